// File: rtl/fifo_arbiter_pkg.sv
// Shared types and constants for the multiplexed readout-source arbiter.
package fifo_arbiter_pkg;

  localparam int unsigned GRANT_ID_W  = 3;
  localparam int unsigned BURST_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational source picker: lowest-index preempting requester first,
// otherwise round-robin starting just above the last granted index.
module rr_priority_picker
  import fifo_arbiter_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]          req_i,
  input  logic [N-1:0]          pre_i,
  input  logic [GRANT_ID_W-1:0] last_i,
  output logic                  found_o,
  output logic [GRANT_ID_W-1:0] idx_o
);

  logic                  pre_found;
  logic [GRANT_ID_W-1:0] pre_idx;
  logic                  rr_found;
  logic [GRANT_ID_W-1:0] rr_idx;
  int unsigned           rr_dist;
  int unsigned           last_u;

  assign last_u = 32'(last_i);

  // Scan from the top so the lowest preempting index is the last one written.
  always_comb begin
    pre_found = 1'b0;
    pre_idx   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[N-1-i] && pre_i[N-1-i]) begin
        pre_found = 1'b1;
        pre_idx   = GRANT_ID_W'(N-1-i);
      end
    end
  end

  // Distance above last grant (with wrap); smallest distance wins.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = '0;
    rr_dist  = N;
    for (int unsigned i = 0; i < N; i++) begin
      if (req_i[i] && (((i + N - 1 - last_u) % N) < rr_dist)) begin
        rr_found = 1'b1;
        rr_idx   = GRANT_ID_W'(i);
        rr_dist  = (i + N - 1 - last_u) % N;
      end
    end
  end

  assign found_o = pre_found | rr_found;
  assign idx_o   = pre_found ? pre_idx : rr_idx;

endmodule

// File: rtl/fifo_source_arbiter.sv
// Shares one downstream FIFO write port between FWFT readout sources using
// bounded-burst round-robin with a non-limited preempt path for trigger words.
module fifo_source_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int unsigned N_SOURCES  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MAX_BURST  = 16
) (
  input  logic                            BUS_CLK,
  input  logic                            BUS_RST,
  input  logic [N_SOURCES-1:0]            SRC_EMPTY,
  input  logic [N_SOURCES*DATA_WIDTH-1:0] SRC_DATA,
  input  logic [N_SOURCES-1:0]            SRC_PREEMPT_REQ,
  output logic [N_SOURCES-1:0]            SRC_READ,
  input  logic                            OUT_FULL,
  output logic                            OUT_WRITE,
  output logic [DATA_WIDTH-1:0]           OUT_DATA,
  output logic                            GRANT_VALID,
  output logic [GRANT_ID_W-1:0]           GRANT_ID
);

  arb_state_e             state_q, state_d;
  logic [GRANT_ID_W-1:0]  grant_id_q, grant_id_d;
  logic [GRANT_ID_W-1:0]  last_grant_q, last_grant_d;
  logic [BURST_CNT_W-1:0] burst_cnt_q, burst_cnt_d;
  logic                   grant_valid_q, grant_valid_d;
  logic                   out_write_q, out_write_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;

  logic                   pick_found_c;
  logic [GRANT_ID_W-1:0]  pick_idx_c;
  logic [N_SOURCES-1:0]   g_onehot_c;
  logic [DATA_WIDTH-1:0]  sel_data_c;
  logic                   g_avail_c;
  logic                   g_pre_c;
  logic                   other_pre_c;
  logic                   read_c;

  rr_priority_picker #(
    .N (N_SOURCES)
  ) u_picker (
    .req_i   (~SRC_EMPTY),
    .pre_i   (SRC_PREEMPT_REQ),
    .last_i  (last_grant_q),
    .found_o (pick_found_c),
    .idx_o   (pick_idx_c)
  );

  // Granted-source decode and N:1 word mux.
  always_comb begin
    g_onehot_c = '0;
    sel_data_c = '0;
    for (int unsigned i = 0; i < N_SOURCES; i++) begin
      if (grant_id_q == GRANT_ID_W'(i)) begin
        g_onehot_c[i] = 1'b1;
        sel_data_c    = SRC_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign g_avail_c   = |(~SRC_EMPTY & g_onehot_c);
  assign g_pre_c     = |(SRC_PREEMPT_REQ & g_onehot_c);
  assign other_pre_c = |(SRC_PREEMPT_REQ & ~SRC_EMPTY & ~g_onehot_c);

  always_comb begin
    state_d       = state_q;
    grant_id_d    = grant_id_q;
    last_grant_d  = last_grant_q;
    burst_cnt_d   = burst_cnt_q;
    grant_valid_d = grant_valid_q;
    out_write_d   = 1'b0;
    out_data_d    = out_data_q;
    read_c        = 1'b0;
    SRC_READ      = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_found_c) begin
          state_d       = ST_GRANT;
          grant_id_d    = pick_idx_c;
          last_grant_d  = pick_idx_c;
          burst_cnt_d   = '0;
          grant_valid_d = 1'b1;
        end
      end

      ST_GRANT: begin
        // No pop during reset so the source never loses a word to the reset cycle.
        read_c   = g_avail_c && !OUT_FULL && !BUS_RST;
        SRC_READ = read_c ? g_onehot_c : '0;
        if (read_c) begin
          out_write_d = 1'b1;
          out_data_d  = sel_data_c;
          if (burst_cnt_q != '1) begin
            burst_cnt_d = burst_cnt_q + 1'b1;
          end
        end
        // Release tests use the post-read burst count.
        if (!g_avail_c ||
            (!g_pre_c && ((burst_cnt_d >= BURST_CNT_W'(MAX_BURST)) || other_pre_c))) begin
          state_d       = ST_RELEASE;
          grant_valid_d = 1'b0;
          grant_id_d    = '0;
        end
      end

      ST_RELEASE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d       = ST_IDLE;
        grant_valid_d = 1'b0;
        grant_id_d    = '0;
      end
    endcase
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state_q       <= ST_IDLE;
      grant_id_q    <= '0;
      last_grant_q  <= GRANT_ID_W'(N_SOURCES - 1);
      burst_cnt_q   <= '0;
      grant_valid_q <= 1'b0;
      out_write_q   <= 1'b0;
      out_data_q    <= '0;
    end else begin
      state_q       <= state_d;
      grant_id_q    <= grant_id_d;
      last_grant_q  <= last_grant_d;
      burst_cnt_q   <= burst_cnt_d;
      grant_valid_q <= grant_valid_d;
      out_write_q   <= out_write_d;
      out_data_q    <= out_data_d;
    end
  end

  assign OUT_WRITE   = out_write_q;
  assign OUT_DATA    = out_data_q;
  assign GRANT_VALID = grant_valid_q;
  assign GRANT_ID    = grant_id_q;

endmodule

// File: tb/tb_fifo_source_arbiter.sv
// Self-checking bench: queue-modelled FWFT sources, per-source expected word
// lists, and burst/latency expectations derived from the arbitration rules.
module tb_fifo_source_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 16;

  logic            BUS_CLK = 1'b0;
  logic            BUS_RST;
  logic [N-1:0]    SRC_EMPTY;
  logic [N*DW-1:0] SRC_DATA;
  logic [N-1:0]    SRC_PREEMPT_REQ;
  logic [N-1:0]    SRC_READ;
  logic            OUT_FULL;
  logic            OUT_WRITE;
  logic [DW-1:0]   OUT_DATA;
  logic            GRANT_VALID;
  logic [2:0]      GRANT_ID;

  fifo_source_arbiter #(
    .N_SOURCES (N), .DATA_WIDTH (DW), .MAX_BURST (MB)
  ) dut (
    .BUS_CLK (BUS_CLK), .BUS_RST (BUS_RST),
    .SRC_EMPTY (SRC_EMPTY), .SRC_DATA (SRC_DATA),
    .SRC_PREEMPT_REQ (SRC_PREEMPT_REQ), .SRC_READ (SRC_READ),
    .OUT_FULL (OUT_FULL), .OUT_WRITE (OUT_WRITE), .OUT_DATA (OUT_DATA),
    .GRANT_VALID (GRANT_VALID), .GRANT_ID (GRANT_ID)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] src_q [N][$];
  logic [DW-1:0] exp_q [N][$];
  int            seq [N];
  logic [N-1:0]  pre_v;
  logic          full_v;
  logic          rst_v;

  int            wr_log[$];
  logic          gv_log[$];
  int            gid_log[$];
  logic [N-1:0]  rd_log[$];
  logic          full_log[$];
  int            run_src[$];
  int            run_len[$];
  int            run_first[$];
  int            run_last[$];

  task automatic push(input int s, input int n);
    for (int k = 0; k < n; k++) begin
      logic [DW-1:0] w;
      w = {8'(s), 8'($urandom), 16'(seq[s])};
      seq[s]++;
      src_q[s].push_back(w);
      exp_q[s].push_back(w);
    end
  endtask

  function automatic bit all_empty();
    for (int s = 0; s < N; s++) if (src_q[s].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_logs();
    wr_log.delete(); gv_log.delete(); gid_log.delete(); rd_log.delete(); full_log.delete();
  endtask

  // One clock: drive inputs, sample at negedge, pop sources after posedge.
  task automatic tick();
    logic [N-1:0] rd;
    logic [DW-1:0] e;
    int ws;
    for (int s = 0; s < N; s++) begin
      SRC_EMPTY[s] = (src_q[s].size() == 0);
      SRC_DATA[s*DW +: DW] = (src_q[s].size() == 0) ? '0 : src_q[s][0];
    end
    SRC_PREEMPT_REQ = pre_v;
    OUT_FULL = full_v;
    BUS_RST = rst_v;
    @(negedge BUS_CLK);
    rd = SRC_READ;
    checks++;
    if (((rd & SRC_EMPTY) != '0) || (OUT_FULL && (rd != '0)) || ($countones(rd) > 1)) begin
      errors++;
      $display("FAIL read_legal: SRC_READ=%b with SRC_EMPTY=%b OUT_FULL=%b, required at most one read of a non-empty source while not full",
               rd, SRC_EMPTY, OUT_FULL);
    end
    ws = -1;
    if (OUT_WRITE === 1'b1) begin
      ws = int'(OUT_DATA[DW-1 -: 8]);
      checks++;
      if (ws >= N || exp_q[ws].size() == 0) begin
        errors++;
        $display("FAIL write_src: OUT_DATA=%h, required a pending word of some source", OUT_DATA);
        ws = -1;
      end else begin
        e = exp_q[ws].pop_front();
        if (OUT_DATA !== e) begin
          errors++;
          $display("FAIL write_order: OUT_DATA=%h, required %h", OUT_DATA, e);
        end
      end
    end
    wr_log.push_back(ws);
    gv_log.push_back(GRANT_VALID);
    gid_log.push_back(int'(GRANT_ID));
    rd_log.push_back(rd);
    full_log.push_back(OUT_FULL);
    @(posedge BUS_CLK);
    #1;
    for (int s = 0; s < N; s++) begin
      if (rd[s] && src_q[s].size() != 0) void'(src_q[s].pop_front());
      if (pre_v[s] && src_q[s].size() == 0) pre_v[s] = 1'b0;
    end
  endtask

  task automatic do_reset();
    for (int s = 0; s < N; s++) begin src_q[s].delete(); exp_q[s].delete(); end
    pre_v = '0; full_v = 1'b0; rst_v = 1'b1;
    tick(); tick();
    rst_v = 1'b0;
    clear_logs();
  endtask

  task automatic drain(input string name, input int bound);
    int n;
    bit done;
    n = 0; done = 1'b0;
    while (!done && n < bound) begin
      tick(); n++;
      done = all_empty() && !gv_log[$] && (wr_log[$] < 0);
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: not idle after %0d cycles, required drain within bound", name, bound);
    end
    repeat (3) tick();
    for (int s = 0; s < N; s++) begin
      checks++;
      if (exp_q[s].size() != 0) begin
        errors++;
        $display("FAIL %s_lost: source %0d has %0d undelivered words, required 0", name, s, exp_q[s].size());
      end
    end
  endtask

  task automatic compute_runs();
    int li;
    run_src.delete(); run_len.delete(); run_first.delete(); run_last.delete();
    foreach (wr_log[c]) begin
      if (wr_log[c] >= 0) begin
        li = run_src.size() - 1;
        if (li >= 0 && run_src[li] == wr_log[c]) begin
          run_len[li] = run_len[li] + 1;
          run_last[li] = c;
        end else begin
          run_src.push_back(wr_log[c]); run_len.push_back(1);
          run_first.push_back(c); run_last.push_back(c);
        end
      end
    end
  endtask

  function automatic int count_grants(input int id);
    int g = 0;
    for (int c = 0; c < gv_log.size(); c++)
      if (gv_log[c] && (c == 0 || !gv_log[c-1]) && gid_log[c] == id) g++;
    return g;
  endfunction

  task automatic check_runs(input string name, input int es[$], input int el[$]);
    compute_runs();
    checks++;
    if (run_src.size() != es.size()) begin
      errors++;
      $display("FAIL %s_run_count: %0d bursts, required %0d", name, run_src.size(), es.size());
    end else begin
      foreach (es[i]) begin
        checks++;
        if (run_src[i] != es[i] || run_len[i] != el[i]) begin
          errors++;
          $display("FAIL %s_run%0d: %0d words of source %0d, required %0d of source %0d",
                   name, i, run_len[i], run_src[i], el[i], es[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    rst_v = 1'b1;
    push(1, 3);
    tick(); tick();
    checks++;
    if (rd_log[$] !== '0 || GRANT_VALID !== 1'b0 || GRANT_ID !== 3'd0 ||
        OUT_WRITE !== 1'b0 || OUT_DATA !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rd=%b gv=%b gid=%0d wr=%b data=%h, required all zero",
               rd_log[$], GRANT_VALID, GRANT_ID, OUT_WRITE, OUT_DATA);
    end
    rst_v = 1'b0;
    clear_logs();
    drain("reset", 50);
  endtask

  task automatic test_single_source();
    int es[$];
    int el[$];
    do_reset();
    push(2, 5);
    drain("single", 60);
    checks++;
    if (gv_log[0] !== 1'b0 || gv_log[1] !== 1'b1 || gid_log[1] != 2) begin
      errors++;
      $display("FAIL single_grant_latency: gv[t]=%b gv[t+1]=%b id=%0d, required 0,1,2", gv_log[0], gv_log[1], gid_log[1]);
    end
    checks++;
    if (rd_log[1] !== 4'b0100) begin
      errors++;
      $display("FAIL single_first_read: SRC_READ[t+1]=%b, required 0100", rd_log[1]);
    end
    es = '{2}; el = '{5};
    check_runs("single", es, el);
    checks++;
    if (run_first.size() != 1 || run_first[0] != 2 || run_last[0] != 6) begin
      errors++;
      $display("FAIL single_write_window: writes not at cycles 2..6 (first=%0d), required 5 back-to-back from t+2",
               run_first.size() > 0 ? run_first[0] : -1);
    end
    checks++;
    if (gv_log[6] !== 1'b1 || gv_log[7] !== 1'b0 || gid_log[7] != 0) begin
      errors++;
      $display("FAIL single_release: gv[6]=%b gv[7]=%b id[7]=%0d, required 1,0,0", gv_log[6], gv_log[7], gid_log[7]);
    end
  endtask

  task automatic test_round_robin();
    int es[$];
    int el[$];
    int rem[2];
    int turn;
    do_reset();
    push(0, 40); push(1, 40);
    drain("rr", 400);
    rem[0] = 40; rem[1] = 40; turn = 0;
    while (rem[0] + rem[1] > 0) begin
      if (rem[turn] > 0) begin
        es.push_back(turn);
        el.push_back(rem[turn] < MB ? rem[turn] : MB);
        rem[turn] -= el[$];
      end
      turn ^= 1;
    end
    check_runs("rr", es, el);
    for (int i = 0; i < run_src.size() && i < 4; i++) begin
      checks++;
      if (run_last[i] - run_first[i] + 1 != run_len[i] || run_first[i+1] - run_last[i] != 3) begin
        errors++;
        $display("FAIL rr_spacing%0d: span=%0d gap=%0d, required span=%0d gap=3",
                 i, run_last[i] - run_first[i] + 1, run_first[i+1] - run_last[i], run_len[i]);
      end
    end
  endtask

  task automatic test_preempt();
    int es[$];
    int el[$];
    int cnt;
    int n;
    do_reset();
    push(1, 20);
    cnt = 0; n = 0;
    while (cnt < 4 && n < 50) begin
      tick(); n++;
      if (rd_log[$][1]) cnt++;
    end
    checks++;
    if (cnt < 4) begin
      errors++;
      $display("FAIL preempt_setup_timeout: %0d reads of source 1, required 4", cnt);
    end
    push(0, 3);
    pre_v[0] = 1'b1;
    drain("preempt", 200);
    es = '{1, 0, 1}; el = '{5, 3, 15};
    check_runs("preempt", es, el);
    checks++;
    if (run_src.size() < 2 || run_last[1] - run_first[1] != 2) begin
      errors++;
      $display("FAIL preempt_contiguous: source 0 words not in 3 consecutive cycles, required contiguous");
    end
  endtask

  task automatic test_preempt_long();
    int es[$];
    int el[$];
    do_reset();
    push(0, 40); push(1, 10);
    pre_v[0] = 1'b1;
    drain("prelong", 300);
    es = '{0, 1}; el = '{40, 10};
    check_runs("prelong", es, el);
    checks++;
    if (run_src.size() < 1 || run_last[0] - run_first[0] != 39 || count_grants(0) != 1) begin
      errors++;
      $display("FAIL prelong_single_grant: grants=%0d, required one grant with 40 contiguous writes", count_grants(0));
    end
  endtask

  task automatic test_backpressure();
    int n;
    int w;
    int tot;
    bit done;
    do_reset();
    push(3, 20);
    pre_v[3] = 1'b1;
    n = 0; done = 1'b0;
    while (!done && n < 300) begin
      full_v = ((n / 3) % 2) == 1;
      tick(); n++;
      done = all_empty() && !gv_log[$] && (wr_log[$] < 0);
    end
    full_v = 1'b0;
    checks++;
    if (!done) begin errors++; $display("FAIL bp_timeout: not drained in 300 cycles, required drain"); end
    drain("bp", 20);
    for (int c = 1; c < full_log.size(); c++) begin
      if (full_log[c] && !full_log[c-1]) begin
        w = 0;
        for (int d = c; d < full_log.size() && full_log[d]; d++) if (wr_log[d] >= 0) w++;
        checks++;
        if (w > 1) begin
          errors++;
          $display("FAIL bp_slack: %0d writes after OUT_FULL rise at %0d, required at most 1", w, c);
        end
      end
    end
    tot = 0;
    foreach (wr_log[c]) if (wr_log[c] == 3) tot++;
    checks++;
    if (tot != 20 || count_grants(3) != 1) begin
      errors++;
      $display("FAIL bp_total: %0d words over %0d grants, required 20 words in 1 grant", tot, count_grants(3));
    end
  endtask

  task automatic test_reset_mid_burst();
    int cnt;
    int n;
    do_reset();
    push(2, 20);
    cnt = 0; n = 0;
    while (cnt < 7 && n < 60) begin
      tick(); n++;
      if (wr_log[$] == 2) cnt++;
    end
    checks++;
    if (cnt < 7) begin errors++; $display("FAIL rstmid_setup_timeout: %0d writes, required 7", cnt); end
    push(0, 4); push(3, 4);
    rst_v = 1'b1;
    tick();
    rst_v = 1'b0;
    checks++;
    if (SRC_READ !== '0 || OUT_WRITE !== 1'b0 || OUT_DATA !== '0 || GRANT_VALID !== 1'b0 || GRANT_ID !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_outputs: rd=%b wr=%b data=%h gv=%b gid=%0d, required all zero",
               SRC_READ, OUT_WRITE, OUT_DATA, GRANT_VALID, GRANT_ID);
    end
    tick(); tick();
    checks++;
    if (gv_log[$] !== 1'b1 || gid_log[$] != 0) begin
      errors++;
      $display("FAIL rstmid_restart: gv=%b id=%0d, required grant to source 0", gv_log[$], gid_log[$]);
    end
    drain("rstmid", 300);
  endtask

  task automatic test_random_traffic();
    int cnt;
    bit in_g;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      for (int s = 0; s < N; s++)
        if ($urandom_range(0, 3) == 0) push(s, int'($urandom_range(1, 3)));
      full_v = ($urandom_range(0, 3) == 0);
      tick();
    end
    full_v = 1'b0;
    drain("random", 1500);
    cnt = 0; in_g = 1'b0;
    foreach (gv_log[c]) begin
      if (gv_log[c]) begin
        cnt += $countones(rd_log[c]);
        in_g = 1'b1;
      end else if (in_g) begin
        checks++;
        if (cnt > MB) begin
          errors++;
          $display("FAIL random_burst: %0d reads in one grant ending at %0d, required at most %0d", cnt, c, MB);
        end
        cnt = 0; in_g = 1'b0;
      end
    end
  endtask

  initial begin
    for (int s = 0; s < N; s++) seq[s] = 0;
    pre_v = '0; full_v = 1'b0; rst_v = 1'b1;
    test_reset();
    test_single_source();
    test_round_robin();
    test_preempt();
    test_preempt_long();
    test_backpressure();
    test_reset_mid_burst();
    test_random_traffic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
